// File: rtl/cnn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cnn_ctrl_pkg
// Shared types for the CNN navigation controller.
//   state_e : settle/valid state of the datapath-timing FSM
//   event_e : the single button event accepted in a cycle, after priority
//   BTN_*   : bit positions of the buttons inside the packed event vector
//   pick_event() : priority encoder clr > next_in > prev_in > next_out > prev_out
// -----------------------------------------------------------------------------
package cnn_ctrl_pkg;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_VALID  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_CLR,
    EV_NEXT_IN,
    EV_PREV_IN,
    EV_NEXT_OUT,
    EV_PREV_OUT
  } event_e;

  localparam int N_BTNS       = 5;
  localparam int BTN_CLR      = 0;
  localparam int BTN_NEXT_IN  = 1;
  localparam int BTN_PREV_IN  = 2;
  localparam int BTN_NEXT_OUT = 3;
  localparam int BTN_PREV_OUT = 4;

  // Lowest bit wins; every other simultaneous event is dropped.
  function automatic event_e pick_event(input logic [N_BTNS-1:0] ev);
    if (ev[BTN_CLR])      return EV_CLR;
    if (ev[BTN_NEXT_IN])  return EV_NEXT_IN;
    if (ev[BTN_PREV_IN])  return EV_PREV_IN;
    if (ev[BTN_NEXT_OUT]) return EV_NEXT_OUT;
    if (ev[BTN_PREV_OUT]) return EV_PREV_OUT;
    return EV_NONE;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Rising-edge detector for one debounced, level-type button.
//   clk     : system clock
//   i_level : current button level
//   o_event : 1 when the level is 1 and the registered previous level is 0
// The history register loads the current level on every edge. Under reset the
// required behaviour is exactly the same (history loads the level, so a button
// held through reset produces no event), hence no separate reset term.
// -----------------------------------------------------------------------------
module btn_edge (
  input  logic clk,
  input  logic i_level,
  output logic o_event
);

  logic r_prev;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    r_prev <= i_level;
  end

  assign o_event = i_level & ~r_prev;

endmodule

// File: rtl/cnn_nav_ctrl.sv
// -----------------------------------------------------------------------------
// cnn_nav_ctrl
// Button-driven navigation for a CNN viewer: selects the input image and an
// output cursor (channel,row,col), then times the datapath settle interval.
//   clk, reset            : clock, synchronous active-high reset
//   btn_clr .. btn_prev_out: debounced level buttons (one accepted per cycle)
//   input_index           : image fed to conv1, wraps 0..N_INPUTS-1
//   chan, row, col        : output cursor, raster order, saturating
//   change                : one-cycle pulse after each accepted update
//   busy, result_valid    : datapath settling / datapath output stable
// -----------------------------------------------------------------------------
module cnn_nav_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int N_INPUTS      = 42,
  parameter int CHANNELS      = 4,
  parameter int DIM           = 5,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        btn_clr,
  input  logic                        btn_next_in,
  input  logic                        btn_prev_in,
  input  logic                        btn_next_out,
  input  logic                        btn_prev_out,
  output logic [$clog2(N_INPUTS)-1:0] input_index,
  output logic [$clog2(CHANNELS)-1:0] chan,
  output logic [$clog2(DIM)-1:0]      row,
  output logic [$clog2(DIM)-1:0]      col,
  output logic                        change,
  output logic                        busy,
  output logic                        result_valid
);

  localparam int IW   = $clog2(N_INPUTS);
  localparam int CW   = $clog2(CHANNELS);
  localparam int DW   = $clog2(DIM);
  localparam int CNTW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [IW-1:0]   IDX_MAX  = IW'(N_INPUTS - 1);
  localparam logic [CW-1:0]   CHAN_MAX = CW'(CHANNELS - 1);
  localparam logic [DW-1:0]   DIM_MAX  = DW'(DIM - 1);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(SETTLE_CYCLES);

  // ---------------------------------------------------------------- buttons
  logic [N_BTNS-1:0] w_levels;
  logic [N_BTNS-1:0] w_events;
  event_e            w_sel;

  always_comb begin
    w_levels               = '0;
    w_levels[BTN_CLR]      = btn_clr;
    w_levels[BTN_NEXT_IN]  = btn_next_in;
    w_levels[BTN_PREV_IN]  = btn_prev_in;
    w_levels[BTN_NEXT_OUT] = btn_next_out;
    w_levels[BTN_PREV_OUT] = btn_prev_out;
  end

  for (genvar g = 0; g < N_BTNS; g++) begin : g_btn
    btn_edge u_edge (
      .clk     (clk),
      .i_level (w_levels[g]),
      .o_event (w_events[g])
    );
  end

  assign w_sel = pick_event(w_events);

  // -------------------------------------------------------- registers
  logic [IW-1:0]   r_index;
  logic [CW-1:0]   r_chan;
  logic [DW-1:0]   r_row;
  logic [DW-1:0]   r_col;
  logic            r_change;
  logic [CNTW-1:0] r_cnt;
  state_e          r_state;

  // ------------------------------------------------- next index / cursor
  logic [IW-1:0] w_idx_nxt;
  logic [CW-1:0] w_chan_nxt;
  logic [DW-1:0] w_row_nxt;
  logic [DW-1:0] w_col_nxt;
  logic          w_upd;
  logic          w_at_last;
  logic          w_at_first;
  state_e        w_state_nxt;

  assign w_at_last  = (r_chan == CHAN_MAX) && (r_row == DIM_MAX) && (r_col == DIM_MAX);
  assign w_at_first = (r_chan == '0) && (r_row == '0) && (r_col == '0);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_idx_nxt  = r_index;
    w_chan_nxt = r_chan;
    w_row_nxt  = r_row;
    w_col_nxt  = r_col;
    w_upd      = 1'b0;
    unique case (w_sel)
      EV_CLR: begin
        w_idx_nxt  = '0;
        w_chan_nxt = '0;
        w_row_nxt  = '0;
        w_col_nxt  = '0;
        w_upd      = 1'b1;
      end
      EV_NEXT_IN: begin
        w_idx_nxt  = (r_index == IDX_MAX) ? '0 : r_index + 1'b1;
        w_chan_nxt = '0;
        w_row_nxt  = '0;
        w_col_nxt  = '0;
        w_upd      = 1'b1;
      end
      EV_PREV_IN: begin
        w_idx_nxt  = (r_index == '0) ? IDX_MAX : r_index - 1'b1;
        w_chan_nxt = '0;
        w_row_nxt  = '0;
        w_col_nxt  = '0;
        w_upd      = 1'b1;
      end
      EV_NEXT_OUT: begin
        // At the last position the event is consumed but changes nothing.
        if (!w_at_last) begin
          w_upd = 1'b1;
          if (r_col != DIM_MAX) begin
            w_col_nxt = r_col + 1'b1;
          end else begin
            w_col_nxt = '0;
            if (r_row != DIM_MAX) begin
              w_row_nxt = r_row + 1'b1;
            end else begin
              w_row_nxt  = '0;
              w_chan_nxt = r_chan + 1'b1;
            end
          end
        end
      end
      EV_PREV_OUT: begin
        if (!w_at_first) begin
          w_upd = 1'b1;
          if (r_col != '0) begin
            w_col_nxt = r_col - 1'b1;
          end else begin
            w_col_nxt = DIM_MAX;
            if (r_row != '0) begin
              w_row_nxt = r_row - 1'b1;
            end else begin
              w_row_nxt  = DIM_MAX;
              w_chan_nxt = r_chan - 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_index  <= '0;
      r_chan   <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_change <= 1'b0;
      r_cnt    <= CNT_LOAD;
    end else begin
      r_change <= w_upd;
      if (w_upd) begin
        r_index <= w_idx_nxt;
        r_chan  <= w_chan_nxt;
        r_row   <= w_row_nxt;
        r_col   <= w_col_nxt;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == ST_SETTLE && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // ------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_SETTLE;
    else       r_state <= w_state_nxt;
  end

  // VALID is entered on the edge that takes the count from 1 to 0, i.e.
  // SETTLE_CYCLES edges after the edge that loaded it.
  always_comb begin
    w_state_nxt = r_state;
    if (w_upd) begin
      w_state_nxt = ST_SETTLE;
    end else if (r_state == ST_SETTLE && r_cnt <= CNTW'(1)) begin
      w_state_nxt = ST_VALID;
    end
  end

  always_comb begin
    busy         = (r_state == ST_SETTLE);
    result_valid = (r_state == ST_VALID);
  end

  assign input_index = r_index;
  assign chan        = r_chan;
  assign row         = r_row;
  assign col         = r_col;
  assign change      = r_change;

endmodule

// File: tb/tb_cnn_nav_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cnn_nav_ctrl
// Self-checking bench: a position-based model (linear cursor index, integer
// image index, integer settle countdown) is compared against every output on
// every falling edge; directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_cnn_nav_ctrl;

  localparam int N_INPUTS      = 42;
  localparam int CHANNELS      = 4;
  localparam int DIM           = 5;
  localparam int SETTLE_CYCLES = 16;
  localparam int TOTAL         = CHANNELS * DIM * DIM;

  localparam logic [4:0] B_CLR      = 5'b00001;
  localparam logic [4:0] B_NEXT_IN  = 5'b00010;
  localparam logic [4:0] B_PREV_IN  = 5'b00100;
  localparam logic [4:0] B_NEXT_OUT = 5'b01000;
  localparam logic [4:0] B_PREV_OUT = 5'b10000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] btn = '0;

  logic [$clog2(N_INPUTS)-1:0] input_index;
  logic [$clog2(CHANNELS)-1:0] chan;
  logic [$clog2(DIM)-1:0]      row;
  logic [$clog2(DIM)-1:0]      col;
  logic change, busy, result_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cnn_nav_ctrl #(
    .N_INPUTS      (N_INPUTS),
    .CHANNELS      (CHANNELS),
    .DIM           (DIM),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_clr      (btn[0]),
    .btn_next_in  (btn[1]),
    .btn_prev_in  (btn[2]),
    .btn_next_out (btn[3]),
    .btn_prev_out (btn[4]),
    .input_index  (input_index),
    .chan         (chan),
    .row          (row),
    .col          (col),
    .change       (change),
    .busy         (busy),
    .result_valid (result_valid)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  bit   m_init   = 0;
  int   m_idx    = 0;
  int   m_pos    = 0;
  int   m_remain = SETTLE_CYCLES;
  bit   m_valid  = 0;
  bit   m_change = 0;
  logic [4:0] m_prev = '0;

  always @(posedge clk) begin
    logic [4:0] ev;
    bit upd;
    upd = 0;
    if (reset) begin
      m_init   = 1;
      m_idx    = 0;
      m_pos    = 0;
      m_remain = SETTLE_CYCLES;
      m_valid  = 0;
      m_change = 0;
      m_prev   = btn;
    end else begin
      ev     = btn & ~m_prev;
      m_prev = btn;
      if (ev[0]) begin
        m_idx = 0; m_pos = 0; upd = 1;
      end else if (ev[1]) begin
        m_idx = (m_idx + 1) % N_INPUTS; m_pos = 0; upd = 1;
      end else if (ev[2]) begin
        m_idx = (m_idx + N_INPUTS - 1) % N_INPUTS; m_pos = 0; upd = 1;
      end else if (ev[3]) begin
        if (m_pos < TOTAL - 1) begin m_pos++; upd = 1; end
      end else if (ev[4]) begin
        if (m_pos > 0) begin m_pos--; upd = 1; end
      end
      m_change = upd;
      if (upd) begin
        m_remain = SETTLE_CYCLES;
        m_valid  = 0;
      end else if (!m_valid) begin
        m_remain--;
        if (m_remain == 0) m_valid = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("input_index",  int'(input_index),  m_idx);
      check("chan",         int'(chan),         m_pos / (DIM * DIM));
      check("row",          int'(row),          (m_pos / DIM) % DIM);
      check("col",          int'(col),          m_pos % DIM);
      check("change",       int'(change),       int'(m_change));
      check("busy",         int'(busy),         int'(!m_valid));
      check("result_valid", int'(result_valid), int'(m_valid));
    end
  end

  // ------------------------------------------------------- stimulus helpers
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the falling edge right after the edge that sampled the press.
  task automatic press(input logic [4:0] mask);
    btn = mask;
    @(negedge clk);
    btn = '0;
  endtask

  task automatic press_n(input logic [4:0] mask, input int n);
    repeat (n) begin
      press(mask);
      tick(1);
    end
  endtask

  // Falling edges waited until result_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) check("wait_valid_timeout", 0, 1);
  endtask

  task automatic check_cursor(input string name, input int c, input int r, input int k);
    check({name, "_chan"}, int'(chan), c);
    check({name, "_row"},  int'(row),  r);
    check({name, "_col"},  int'(col),  k);
  endtask

  // ------------------------------------------------------------ scenarios
  initial begin
    int n;
    reset = 1'b1;
    btn   = '0;
    tick(3);
    check("rst_index",  int'(input_index), 0);
    check_cursor("rst", 0, 0, 0);
    check("rst_change", int'(change), 0);
    check("rst_busy",   int'(busy), 1);
    check("rst_valid",  int'(result_valid), 0);

    // Power-up settle
    reset = 1'b0;
    wait_valid(n);
    check("powerup_settle", n, 16);
    check("powerup_busy", int'(busy), 0);

    // prev_in wraps 0 -> 41
    tick(1);
    press(B_PREV_IN);
    check("prev_in_wrap", int'(input_index), 41);
    check("prev_in_change", int'(change), 1);
    check("prev_in_valid_drop", int'(result_valid), 0);
    wait_valid(n);
    check("prev_in_settle", n, 16);

    // next_in wraps 41 -> 0
    tick(1);
    press(B_NEXT_IN);
    check("next_in_wrap", int'(input_index), 0);
    tick(1);

    // Cursor raster stepping
    press(B_CLR);
    tick(1);
    press_n(B_NEXT_OUT, 4);
    check_cursor("c004", 0, 0, 4);
    press(B_NEXT_OUT);
    check_cursor("c010", 0, 1, 0);
    check("c010_change", int'(change), 1);
    tick(1);
    press(B_PREV_OUT);
    check_cursor("back004", 0, 0, 4);
    tick(1);
    press_n(B_NEXT_OUT, 95);
    check_cursor("c344", 3, 4, 4);
    wait_valid(n);
    press(B_NEXT_OUT);
    check_cursor("sat344", 3, 4, 4);
    check("sat_change", int'(change), 0);
    check("sat_valid", int'(result_valid), 1);
    tick(1);

    // Simultaneous next_in + next_out: next_out discarded
    press(B_CLR);
    tick(1);
    press_n(B_NEXT_IN, 5);
    press_n(B_NEXT_OUT, 38);
    check("pre_sim_index", int'(input_index), 5);
    check_cursor("pre_sim", 1, 2, 3);
    press(B_NEXT_IN | B_NEXT_OUT);
    check("sim_index", int'(input_index), 6);
    check_cursor("sim", 0, 0, 0);
    tick(1);

    // Held button: one event only
    btn = B_NEXT_IN;
    tick(100);
    btn = '0;
    tick(1);
    check("held_index", int'(input_index), 7);

    // Restart of settle interval: t0 then t0+10 -> valid at t0+26
    wait_valid(n);
    press(B_NEXT_OUT);
    tick(9);
    press(B_NEXT_OUT);
    check_cursor("restart", 0, 0, 2);
    wait_valid(n);
    check("restart_total", 10 + n, 26);

    // Reset mid-settle with a button held
    tick(1);
    press(B_PREV_OUT);
    tick(11);
    check("mid_busy", int'(busy), 1);
    btn   = B_PREV_IN;
    reset = 1'b1;
    tick(2);
    check("mid_rst_index", int'(input_index), 0);
    check_cursor("mid_rst", 0, 0, 0);
    check("mid_rst_busy", int'(busy), 1);
    reset = 1'b0;
    wait_valid(n);
    check("held_through_rst_settle", n, 16);
    check("held_through_rst_index", int'(input_index), 0);
    btn = '0;
    tick(1);
    press(B_PREV_IN);
    check("repress_index", int'(input_index), 41);
    wait_valid(n);
    check("repress_settle", n, 16);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
